// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto a 4-beat x 64-bit burst memory port
module mem_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_pmem_read,
   input  logic [31:0]  i_pmem_address,
   output logic [255:0] i_pmem_rdata,
   output logic         i_pmem_resp,
   input  logic         d_pmem_read,
   input  logic         d_pmem_write,
   input  logic [31:0]  d_pmem_address,
   input  logic [255:0] d_pmem_wdata,
   output logic [255:0] d_pmem_rdata,
   output logic         d_pmem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [63:0]  pmem_wdata,
   input  logic [63:0]  pmem_rdata,
   input  logic         pmem_resp
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_I_READ  = 3'd1;
   localparam logic [2:0] S_D_READ  = 3'd2;
   localparam logic [2:0] S_D_WRITE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]   state_q, state_d;
   logic [1:0]   beat_q, beat_d;
   logic         last_d_q, last_d_d;      // 1 = dcache was served last
   logic [26:0]  addr_q, addr_d;
   logic [255:0] wline_q, wline_d;
   logic [255:0] rline_q, rline_d;

   logic d_req;
   logic grant_d;
   logic unused_addr_bits;

   assign d_req            = d_pmem_read | d_pmem_write;
   assign grant_d          = d_req & (~i_pmem_read | ~last_d_q);
   assign unused_addr_bits = ^{i_pmem_address[4:0], d_pmem_address[4:0]};

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      wline_d  = wline_q;
      rline_d  = rline_q;
      case (state_q)
         S_IDLE: begin
            if (grant_d) begin
               addr_d = d_pmem_address[31:5];
               if (d_pmem_write) begin
                  state_d = S_D_WRITE;
                  wline_d = d_pmem_wdata;
               end else begin
                  state_d = S_D_READ;
               end
            end else if (i_pmem_read) begin
               addr_d  = i_pmem_address[31:5];
               state_d = S_I_READ;
            end
         end
         S_I_READ, S_D_READ, S_D_WRITE: begin
            if (pmem_resp) begin
               if (state_q != S_D_WRITE) begin
                  rline_d[{beat_q, 6'd0} +: 64] = pmem_rdata;
               end
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  state_d  = S_DONE;
                  last_d_d = (state_q != S_I_READ);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         beat_q   <= 2'd0;
         last_d_q <= 1'b0;
         addr_q   <= '0;
         wline_q  <= '0;
         rline_q  <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         wline_q  <= wline_d;
         rline_q  <= rline_d;
      end
   end

   // Both clients see the shared line buffer; only the resp flags are steered.
   assign i_pmem_rdata = rline_q;
   assign d_pmem_rdata = rline_q;
   assign i_pmem_resp  = (state_q == S_DONE) & ~last_d_q;
   assign d_pmem_resp  = (state_q == S_DONE) &  last_d_q;
   assign pmem_read    = (state_q == S_I_READ) | (state_q == S_D_READ);
   assign pmem_write   = (state_q == S_D_WRITE);
   assign pmem_address = {addr_q, 5'b0};
   assign pmem_wdata   = wline_q[{beat_q, 6'd0} +: 64];

endmodule
